// File: rtl/sync_memory_if.sv
// ---------------------------------------------------------------------------
// sync_memory_if
// Request/response bundle for sync_memory.
//   clr        : start a clear sweep (honoured only while idle)
//   req_valid  : request present
//   req_ready  : memory can accept a request this cycle
//   req_write  : 1 = write, 0 = read
//   req_addr   : word address
//   req_data   : write data
//   resp_valid : one-cycle pulse, read data valid
//   resp_data  : read data, holds between responses
//   busy       : clear sweep in progress
// master = requester side, slave = memory side.
// ---------------------------------------------------------------------------
interface sync_memory_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8
);
  logic                 clr;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [WORD_SIZE-1:0] req_data;
  logic                 resp_valid;
  logic [WORD_SIZE-1:0] resp_data;
  logic                 busy;

  modport master (
    output clr,
    output req_valid,
    input  req_ready,
    output req_write,
    output req_addr,
    output req_data,
    input  resp_valid,
    input  resp_data,
    input  busy
  );

  modport slave (
    input  clr,
    input  req_valid,
    output req_ready,
    input  req_write,
    input  req_addr,
    input  req_data,
    output resp_valid,
    output resp_data,
    output busy
  );
endinterface

// File: rtl/sync_memory.sv
// ---------------------------------------------------------------------------
// sync_memory
// Single-port synchronous word memory with a valid/ready request port,
// registered read data and a one-word-per-cycle clear sequencer.
//
// Parameters
//   WORD_SIZE    : data width in bits
//   ADDR_SIZE    : address width, depth = 2**ADDR_SIZE words
//   CLEAR_ON_RST : 1 = reset starts a full clear sweep, 0 = reset keeps data
//
// Ports
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : sync_memory_if.slave (request, response, clr and busy signals)
//
// A request is accepted on an edge where req_valid && req_ready. Reads
// answer one cycle later with a single-cycle resp_valid pulse; writes give
// no response. While a sweep runs, requests and clr are ignored.
// ---------------------------------------------------------------------------
module sync_memory #(
  parameter int WORD_SIZE    = 16,
  parameter int ADDR_SIZE    = 8,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  sync_memory_if.slave bus
);

  localparam int                   DEPTH    = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE-1:0] MAX_ADDR = {ADDR_SIZE{1'b1}};

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [ADDR_SIZE-1:0] clr_addr_q;
  logic [WORD_SIZE-1:0] mem [DEPTH];

  logic                 accept;
  logic                 rd_accept;
  logic                 wr_accept;
  logic                 sweep_last;

  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_waddr;
  logic [WORD_SIZE-1:0] mem_wdata;

  logic                 resp_valid_q;
  logic [WORD_SIZE-1:0] resp_data_q;

  // Acceptance depends only on the registered state and req_valid, so
  // req_ready itself never has a path from any input.
  assign accept     = (state_q == IDLE) && bus.req_valid;
  assign rd_accept  = accept && !bus.req_write;
  assign wr_accept  = accept &&  bus.req_write;
  assign sweep_last = (clr_addr_q == MAX_ADDR);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR_ON_RST ? CLEAR : IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (sweep_last) state_d = IDLE;
      IDLE:    if (bus.clr)    state_d = CLEAR;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: both flags are pure functions of the registered state
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.busy      = (state_q == CLEAR);
  end

  // Sweep address. It wraps MAX_ADDR -> 0 on exactly the edge that leaves
  // CLEAR, so it sits at 0 whenever the sequencer is idle; the explicit
  // reload on clr keeps that true even if the counter was ever disturbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr_q <= '0;
    end else if (state_q == CLEAR) begin
      clr_addr_q <= clr_addr_q + 1'b1;
    end else if (bus.clr) begin
      clr_addr_q <= '0;
    end
  end

  // Single write port shared by the sweep and accepted write requests.
  // The sweep owns the port in CLEAR; no write at all happens on an rst edge.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.req_addr;
    mem_wdata = bus.req_data;
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
        mem_wdata = '0;
      end else if (wr_accept) begin
        mem_we = 1'b1;
      end
    end
  end

  // Storage array, no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read path; resp_data holds its value between responses
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= rd_accept;
      if (rd_accept) begin
        resp_data_q <= mem[bus.req_addr];
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_sync_memory.sv
// ---------------------------------------------------------------------------
// tb_sync_memory
// Self-checking bench for sync_memory. One instance clears on reset, a
// second one does not. Inputs change on the falling edge, outputs are
// sampled on the falling edge. A behavioural model (word array plus a
// count of remaining sweep cycles) predicts every output.
// ---------------------------------------------------------------------------
module tb_sync_memory;

  localparam int WS    = 16;
  localparam int AS    = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  logic rst_nc;

  always #5 clk = ~clk;

  sync_memory_if #(.WORD_SIZE(WS), .ADDR_SIZE(AS)) bus ();
  sync_memory_if #(.WORD_SIZE(WS), .ADDR_SIZE(AS)) bus_nc ();

  sync_memory #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .CLEAR_ON_RST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sync_memory #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .CLEAR_ON_RST(1'b0)) dut_nc (
    .clk (clk),
    .rst (rst_nc),
    .bus (bus_nc)
  );

  // Reference model: contents, cycles of sweep left, expected response
  logic [WS-1:0] m_mem [DEPTH];
  int            clear_left;
  logic          m_rv;
  logic [WS-1:0] m_rd;

  int n_checks;
  int n_fail;

  typedef struct {
    logic          v;
    logic          w;
    logic [AS-1:0] a;
    logic [WS-1:0] d;
    logic          exp_rv;
    logic [WS-1:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Effect of one rising edge, written from the memory's rules
  task automatic modelEdge(input logic r, input logic c, input logic v, input logic w,
                           input logic [AS-1:0] a, input logic [WS-1:0] d);
    if (r) begin
      clear_left = DEPTH;
      m_rv = 1'b0;
      m_rd = '0;
    end else if (clear_left > 0) begin
      clear_left--;
      m_rv = 1'b0;
      if (clear_left == 0) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end else begin
      m_rv = 1'b0;
      if (v) begin
        if (w) begin
          m_mem[a] = d;
        end else begin
          m_rv = 1'b1;
          m_rd = m_mem[a];
        end
      end
      if (c) clear_left = DEPTH;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic v, input logic w,
                               input logic [AS-1:0] a, input logic [WS-1:0] d);
    rst           = r;
    bus.clr       = c;
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_data  = d;
    @(posedge clk);
    modelEdge(r, c, v, w, a, d);
    @(negedge clk);
  endtask

  task automatic compareModel(input string tag);
    checkOutput({tag, "/ready"},      32'(bus.req_ready),  32'(clear_left == 0));
    checkOutput({tag, "/busy"},       32'(bus.busy),       32'(clear_left != 0));
    checkOutput({tag, "/resp_valid"}, 32'(bus.resp_valid), 32'(m_rv));
    checkOutput({tag, "/resp_data"},  32'(bus.resp_data),  32'(m_rd));
  endtask

  // Run edges until busy drops (bounded), holding an optional read request
  task automatic waitSweep(input string tag, input int exp_edges, input logic hold_valid);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 2000) begin
      applyStimulus(1'b0, 1'b0, hold_valid, 1'b0, 8'h00, 16'h0000);
      compareModel(tag);
      n++;
    end
    checkOutput({tag, "/sweep_len"}, 32'(n), 32'(exp_edges));
  endtask

  task automatic ncEdge(input logic r, input logic v, input logic w,
                        input logic [AS-1:0] a, input logic [WS-1:0] d);
    rst_nc           = r;
    bus_nc.clr       = 1'b0;
    bus_nc.req_valid = v;
    bus_nc.req_write = w;
    bus_nc.req_addr  = a;
    bus_nc.req_data  = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [AS-1:0] rd_addrs [3];
    logic          r, c, v, w;
    logic [AS-1:0] a;
    logic [WS-1:0] d;

    n_checks   = 0;
    n_fail     = 0;
    clear_left = 0;
    m_rv       = 1'b0;
    m_rd       = '0;

    rd_addrs[0] = 8'h00;
    rd_addrs[1] = 8'h80;
    rd_addrs[2] = 8'hFF;

    // v, w, addr, data, expected resp_valid, expected resp_data
    vecs[0] = '{1'b1, 1'b1, 8'h12, 16'hBEEF, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 8'h12, 16'h0000, 1'b1, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 8'h13, 16'h1234, 1'b0, 16'hBEEF};
    vecs[3] = '{1'b1, 1'b0, 8'h12, 16'h0000, 1'b1, 16'hBEEF};
    vecs[4] = '{1'b1, 1'b0, 8'h13, 16'h0000, 1'b1, 16'h1234};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h1234};
    vecs[6] = '{1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h0000};
    vecs[7] = '{1'b1, 1'b1, 8'h12, 16'h0F0F, 1'b0, 16'h0000};
    vecs[8] = '{1'b1, 1'b0, 8'h12, 16'h0000, 1'b1, 16'h0F0F};

    rst = 1'b0;
    rst_nc = 1'b0;
    bus.clr = 1'b0; bus.req_valid = 1'b0; bus.req_write = 1'b0;
    bus.req_addr = '0; bus.req_data = '0;
    bus_nc.clr = 1'b0; bus_nc.req_valid = 1'b0; bus_nc.req_write = 1'b0;
    bus_nc.req_addr = '0; bus_nc.req_data = '0;
    @(negedge clk);

    // Reset launches a 256-cycle sweep; a held read is never accepted
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkOutput("rst/ready", 32'(bus.req_ready), 0);
    checkOutput("rst/busy", 32'(bus.busy), 1);
    checkOutput("rst/resp_valid", 32'(bus.resp_valid), 0);
    checkOutput("rst/resp_data", 32'(bus.resp_data), 0);
    waitSweep("init", 256, 1'b1);
    checkOutput("init/ready_after", 32'(bus.req_ready), 1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, rd_addrs[i], 16'h0000);
      checkOutput("init_read/valid", 32'(bus.resp_valid), 1);
      checkOutput("init_read/data", 32'(bus.resp_data), 0);
    end

    // Table of writes, read-after-write and back-to-back reads
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b0, vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].d);
      checkOutput($sformatf("vec%0d/resp_valid", i), 32'(bus.resp_valid), 32'(vecs[i].exp_rv));
      checkOutput($sformatf("vec%0d/resp_data", i), 32'(bus.resp_data), 32'(vecs[i].exp_rd));
      compareModel($sformatf("vec%0d", i));
    end

    // clr together with a write: write lands, then the sweep wipes it
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 16'hAAAA);
    checkOutput("clr/busy", 32'(bus.busy), 1);
    checkOutput("clr/ready", 32'(bus.req_ready), 0);
    waitSweep("clr", 256, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 16'h0000);
    checkOutput("clr_read05/valid", 32'(bus.resp_valid), 1);
    checkOutput("clr_read05/data", 32'(bus.resp_data), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h12, 16'h0000);
    checkOutput("clr_read12/data", 32'(bus.resp_data), 0);

    // Reset at sweep cycle 100 restarts the full sweep
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'hC8, 16'hFFFF);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    end
    checkOutput("mid/busy_before", 32'(bus.busy), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    compareModel("mid_rst");
    waitSweep("restart", 256, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'hC8, 16'h0000);
    checkOutput("restart_readC8/data", 32'(bus.resp_data), 0);

    // Reset right after a read acceptance drops that response
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 16'h1357);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 16'h0000);
    checkOutput("rdrst/valid_before", 32'(bus.resp_valid), 1);
    checkOutput("rdrst/data_before", 32'(bus.resp_data), 32'h1357);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkOutput("rdrst/valid_after", 32'(bus.resp_valid), 0);
    checkOutput("rdrst/data_after", 32'(bus.resp_data), 0);
    waitSweep("rdrst", 256, 1'b0);

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 99) == 0);
      v = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 255));
      else                           a = 8'($urandom_range(0, 15));
      d = 16'($urandom);
      applyStimulus(r, c, v, w, a, d);
      compareModel("rand");
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);

    // Instance without clear-on-reset keeps its contents across reset
    ncEdge(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkOutput("nc_rst/ready", 32'(bus_nc.req_ready), 1);
    checkOutput("nc_rst/busy", 32'(bus_nc.busy), 0);
    checkOutput("nc_rst/resp_valid", 32'(bus_nc.resp_valid), 0);
    checkOutput("nc_rst/resp_data", 32'(bus_nc.resp_data), 0);
    ncEdge(1'b0, 1'b1, 1'b1, 8'hFF, 16'h5A5A);
    ncEdge(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkOutput("nc_rst2/ready", 32'(bus_nc.req_ready), 1);
    checkOutput("nc_rst2/busy", 32'(bus_nc.busy), 0);
    ncEdge(1'b0, 1'b1, 1'b0, 8'hFF, 16'h0000);
    checkOutput("nc_readFF/valid", 32'(bus_nc.resp_valid), 1);
    checkOutput("nc_readFF/data", 32'(bus_nc.resp_data), 32'h5A5A);
    ncEdge(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkOutput("nc_idle/valid", 32'(bus_nc.resp_valid), 0);
    checkOutput("nc_idle/data_hold", 32'(bus_nc.resp_data), 32'h5A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
